// File: rtl/calc3_pkg.sv
// Shared types and command decode for the calc3 priority-to-adder dispatch path.
package calc3_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = 2;
  localparam int unsigned SEQ_W     = 2;
  localparam int unsigned TAG_W     = PORT_W + SEQ_W;

  localparam logic [0:3] CMD_ADD = 4'b0001;
  localparam logic [0:3] CMD_SUB = 4'b0010;
  localparam logic [0:3] CMD_BZ  = 4'b1100;
  localparam logic [0:3] CMD_BEQ = 4'b1101;

  typedef struct packed {
    logic [0:3] cmd;
    logic [0:4] data1;
    logic [0:4] data2;
    logic [0:4] result;
    logic [0:4] follow_branch;
  } req_entry_t;

  function automatic logic cmd_is_branch(input logic [0:3] cmd);
    return (cmd == CMD_BZ) || (cmd == CMD_BEQ);
  endfunction

  function automatic logic cmd_is_legal(input logic [0:3] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || cmd_is_branch(cmd);
  endfunction

endpackage

// File: rtl/adder_dispatch_fifo.sv
// Per-port request queue; wrap-bit pointers distinguish full from empty.
module adder_dispatch_fifo
  import calc3_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t wdata,
  input  logic       pop,
  output req_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(QDEPTH);

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  req_entry_t  mem_q [QDEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_ff @(negedge c_clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset; a simultaneous pop reads the old head before it is overwritten.
  always_ff @(negedge c_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/adder_dispatch.sv
// Four-port round-robin dispatcher onto the prio_adder bus with per-port credits.
// Optional CALC3_DISPATCH_ILLEGAL_CNT_EN adds a saturating illegal-command counter.
module adder_dispatch
  import calc3_pkg::*;
#(
  parameter int unsigned QDEPTH       = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       req1_vld,
  input  logic [0:3] req1_cmd,
  input  logic [0:4] req1_data1,
  input  logic [0:4] req1_data2,
  input  logic [0:4] req1_result,
  input  logic [0:4] req1_follow_branch,
  output logic       req1_ack,
  input  logic       req2_vld,
  input  logic [0:3] req2_cmd,
  input  logic [0:4] req2_data1,
  input  logic [0:4] req2_data2,
  input  logic [0:4] req2_result,
  input  logic [0:4] req2_follow_branch,
  output logic       req2_ack,
  input  logic       req3_vld,
  input  logic [0:3] req3_cmd,
  input  logic [0:4] req3_data1,
  input  logic [0:4] req3_data2,
  input  logic [0:4] req3_result,
  input  logic [0:4] req3_follow_branch,
  output logic       req3_ack,
  input  logic       req4_vld,
  input  logic [0:3] req4_cmd,
  input  logic [0:4] req4_data1,
  input  logic [0:4] req4_data2,
  input  logic [0:4] req4_result,
  input  logic [0:4] req4_follow_branch,
  output logic       req4_ack,
  input  logic       done1,
  input  logic       done2,
  input  logic       done3,
  input  logic       done4,
  output logic       prio_adder_out_vld,
  output logic [0:3] prio_adder_cmd,
  output logic [0:3] prio_adder_tag,
  output logic [0:4] prio_adder_data1,
  output logic [0:4] prio_adder_data2,
  output logic [0:4] prio_adder_follow_branch,
  output logic [0:4] prio_adder_result
`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
  ,
  output logic [0:7] illegal_cnt
`endif
);

  localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);

  req_entry_t            req  [NUM_PORTS];
  req_entry_t            head [NUM_PORTS];
  logic [NUM_PORTS-1:0]  vld, done, ack, legal, push, pop, full, empty, eligible;
  logic [IF_W-1:0]       inflight_q [NUM_PORTS];
  logic [IF_W-1:0]       inflight_d [NUM_PORTS];
  logic [SEQ_W-1:0]      seq_q      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  bp_q, bp_d;
  logic [PORT_W-1:0]     last_q, grant_idx, cand;
  logic                  grant_vld;
  logic                  rdy_q;
  req_entry_t            gnt_entry;

  assign req[0] = {req1_cmd, req1_data1, req1_data2, req1_result, req1_follow_branch};
  assign req[1] = {req2_cmd, req2_data1, req2_data2, req2_result, req2_follow_branch};
  assign req[2] = {req3_cmd, req3_data1, req3_data2, req3_result, req3_follow_branch};
  assign req[3] = {req4_cmd, req4_data1, req4_data2, req4_result, req4_follow_branch};
  assign vld    = {req4_vld, req3_vld, req2_vld, req1_vld};
  assign done   = {done4, done3, done2, done1};
  assign req1_ack = ack[0];
  assign req2_ack = ack[1];
  assign req3_ack = ack[2];
  assign req4_ack = ack[3];

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    // rdy_q keeps ack low until the first edge after reset is released.
    assign ack[n]      = rdy_q && !full[n] && !reset;
    assign legal[n]    = cmd_is_legal(req[n].cmd);
    assign push[n]     = vld[n] && ack[n] && legal[n];
    assign eligible[n] = !empty[n] && (inflight_q[n] < IF_W'(MAX_INFLIGHT)) && !bp_q[n];
    assign pop[n]      = grant_vld && (grant_idx == PORT_W'(n));

    adder_dispatch_fifo #(
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .c_clk (c_clk),
      .reset (reset),
      .push  (push[n]),
      .wdata (req[n]),
      .pop   (pop[n]),
      .rdata (head[n]),
      .full  (full[n]),
      .empty (empty[n])
    );
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = last_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = last_q + PORT_W'(i);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign gnt_entry = head[grant_idx];

  always_comb begin
    for (int n = 0; n < NUM_PORTS; n++) begin
      inflight_d[n] = inflight_q[n];
      if (pop[n] && !(done[n] && inflight_q[n] != '0)) begin
        inflight_d[n] = inflight_q[n] + IF_W'(1);
      end else if (!pop[n] && done[n] && inflight_q[n] != '0) begin
        inflight_d[n] = inflight_q[n] - IF_W'(1);
      end
      bp_d[n] = bp_q[n];
      if (pop[n] && cmd_is_branch(head[n].cmd)) begin
        bp_d[n] = 1'b1;
      end else if (inflight_d[n] == '0) begin
        bp_d[n] = 1'b0;
      end
    end
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      rdy_q                    <= 1'b0;
      last_q                   <= PORT_W'(NUM_PORTS - 1);
      prio_adder_out_vld       <= 1'b0;
      prio_adder_cmd           <= '0;
      prio_adder_tag           <= '0;
      prio_adder_data1         <= '0;
      prio_adder_data2         <= '0;
      prio_adder_follow_branch <= '0;
      prio_adder_result        <= '0;
      bp_q                     <= '0;
      for (int n = 0; n < NUM_PORTS; n++) begin
        seq_q[n]      <= '0;
        inflight_q[n] <= '0;
      end
    end else begin
      rdy_q              <= 1'b1;
      prio_adder_out_vld <= grant_vld;
      if (grant_vld) begin
        prio_adder_cmd           <= gnt_entry.cmd;
        prio_adder_tag           <= {grant_idx, seq_q[grant_idx]};
        prio_adder_data1         <= gnt_entry.data1;
        prio_adder_data2         <= gnt_entry.data2;
        prio_adder_follow_branch <= gnt_entry.follow_branch;
        prio_adder_result        <= gnt_entry.result;
        last_q                   <= grant_idx;
        seq_q[grant_idx]         <= seq_q[grant_idx] + SEQ_W'(1);
      end
      bp_q <= bp_d;
      for (int n = 0; n < NUM_PORTS; n++) begin
        inflight_q[n] <= inflight_d[n];
      end
    end
  end

`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
  logic [7:0] ill_cnt_q;
  logic [8:0] ill_sum;

  always_comb begin
    ill_sum = {1'b0, ill_cnt_q};
    for (int n = 0; n < NUM_PORTS; n++) begin
      ill_sum = ill_sum + 9'(vld[n] && ack[n] && !legal[n]);
    end
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_sum[8] ? 8'hff : ill_sum[7:0];
    end
  end

  assign illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_adder_dispatch.sv
// Directed bench for adder_dispatch: vector table plus multi-cycle scenarios.
module tb_adder_dispatch;

  logic       c_clk = 1'b0;
  logic       reset;
  logic [3:0] vld, done, ack;
  logic [0:3] cmd [4];
  logic [0:4] d1 [4];
  logic [0:4] d2 [4];
  logic [0:4] res [4];
  logic [0:4] fb [4];
  logic       out_vld;
  logic [0:3] o_cmd, o_tag;
  logic [0:4] o_d1, o_d2, o_fb, o_res;
`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
  logic [0:7] ill_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 c_clk = ~c_clk;

  adder_dispatch dut (
    .c_clk                    (c_clk),
    .reset                    (reset),
    .req1_vld (vld[0]), .req1_cmd (cmd[0]), .req1_data1 (d1[0]), .req1_data2 (d2[0]),
    .req1_result (res[0]), .req1_follow_branch (fb[0]), .req1_ack (ack[0]),
    .req2_vld (vld[1]), .req2_cmd (cmd[1]), .req2_data1 (d1[1]), .req2_data2 (d2[1]),
    .req2_result (res[1]), .req2_follow_branch (fb[1]), .req2_ack (ack[1]),
    .req3_vld (vld[2]), .req3_cmd (cmd[2]), .req3_data1 (d1[2]), .req3_data2 (d2[2]),
    .req3_result (res[2]), .req3_follow_branch (fb[2]), .req3_ack (ack[2]),
    .req4_vld (vld[3]), .req4_cmd (cmd[3]), .req4_data1 (d1[3]), .req4_data2 (d2[3]),
    .req4_result (res[3]), .req4_follow_branch (fb[3]), .req4_ack (ack[3]),
    .done1 (done[0]), .done2 (done[1]), .done3 (done[2]), .done4 (done[3]),
    .prio_adder_out_vld       (out_vld),
    .prio_adder_cmd           (o_cmd),
    .prio_adder_tag           (o_tag),
    .prio_adder_data1         (o_d1),
    .prio_adder_data2         (o_d2),
    .prio_adder_follow_branch (o_fb),
    .prio_adder_result        (o_res)
`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
    ,
    .illegal_cnt              (ill_cnt)
`endif
  );

  typedef struct {
    int         port;
    logic [0:3] cmd;
    logic [0:4] d1, d2, res, fb;
    logic       exp_vld;
    logic [0:3] exp_tag;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Advance over one active (falling) edge and settle.
  task automatic cyc();
    @(negedge c_clk);
    #1;
  endtask

  task automatic clear_inputs();
    vld  = '0;
    done = '0;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = '0; d1[p] = '0; d2[p] = '0; res[p] = '0; fb[p] = '0;
    end
  endtask

  task automatic put_req(input int p, input logic [0:3] c, input logic [0:4] a,
                         input logic [0:4] b, input logic [0:4] r, input logic [0:4] f);
    cmd[p] = c; d1[p] = a; d2[p] = b; res[p] = r; fb[p] = f; vld[p] = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  function automatic logic [31:0] out_bus();
    return 32'({o_cmd, o_tag, o_d1, o_d2, o_res, o_fb});
  endfunction

  logic [0:3] ft [5];
  int         cnt;

  initial begin
    tv[0] = '{0, 4'b0001, 5'b10011, 5'b10100, 5'b00101, 5'b00000, 1'b1, 4'b0000};
    tv[1] = '{1, 4'b0010, 5'b00001, 5'b11111, 5'b01010, 5'b00011, 1'b1, 4'b0100};
    tv[2] = '{2, 4'b0001, 5'b11110, 5'b00111, 5'b11001, 5'b01000, 1'b1, 4'b1000};
    tv[3] = '{3, 4'b1100, 5'b10001, 5'b00000, 5'b00010, 5'b10101, 1'b1, 4'b1100};
    tv[4] = '{3, 4'b0101, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 1'b0, 4'b0000};
    tv[5] = '{0, 4'b1101, 5'b10110, 5'b11000, 5'b00100, 5'b01111, 1'b1, 4'b0001};
    tv[6] = '{1, 4'b1111, 5'b10101, 5'b01010, 5'b10101, 5'b01010, 1'b0, 4'b0000};
    tv[7] = '{3, 4'b0010, 5'b01101, 5'b10010, 5'b11100, 5'b00001, 1'b1, 4'b1101};
    ft[0] = 4'b0000; ft[1] = 4'b0100; ft[2] = 4'b1000; ft[3] = 4'b1100; ft[4] = 4'b0001;

    // Reset state
    clear_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    chk("reset_out_vld", 32'(out_vld), 0);
    chk("reset_bus", out_bus(), 0);
    chk("reset_ack", 32'(ack), 0);
    reset = 1'b0;
    #1;
    chk("ack_before_first_edge", 32'(ack), 0);
    cyc();
    chk("ack_after_first_edge", 32'(ack), 32'hf);
`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
    chk("reset_illegal_cnt", 32'(ill_cnt), 0);
`endif

    // Vector table: one push, dispatch next edge, then retire
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("v%0d_ack", v), 32'(ack[tv[v].port]), 1);
      put_req(tv[v].port, tv[v].cmd, tv[v].d1, tv[v].d2, tv[v].res, tv[v].fb);
      cyc();
      clear_inputs();
      cyc();
      chk($sformatf("v%0d_out_vld", v), 32'(out_vld), 32'(tv[v].exp_vld));
      if (tv[v].exp_vld) begin
        chk($sformatf("v%0d_bus", v), out_bus(),
            32'({tv[v].cmd, tv[v].exp_tag, tv[v].d1, tv[v].d2, tv[v].res, tv[v].fb}));
        done[tv[v].port] = 1'b1;
        cyc();
        clear_inputs();
      end
    end

    // Simultaneous illegal pushes on all ports
    for (int p = 0; p < 4; p++) put_req(p, 4'b0111, 5'd1, 5'd2, 5'd3, 5'd4);
    cyc();
    clear_inputs();
    cyc();
    chk("multi_illegal_no_dispatch", 32'(out_vld), 0);
`ifdef CALC3_DISPATCH_ILLEGAL_CNT_EN
    chk("illegal_cnt", 32'(ill_cnt), 6);
`endif

    // Fairness: all ports hold vld
    do_reset();
    for (int p = 0; p < 4; p++) put_req(p, 4'b0001, 5'(p + 1), 5'b00000, 5'b00001, 5'b00000);
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("rr%0d_vld", k), 32'(out_vld), 1);
      chk($sformatf("rr%0d_tag", k), 32'(o_tag), 32'(ft[k]));
    end

    // Mid-run reset with queues occupied and commands in flight
    reset = 1'b1;
    cyc();
    chk("midrst_out_vld", 32'(out_vld), 0);
    chk("midrst_bus", out_bus(), 0);
    chk("midrst_ack", 32'(ack), 0);
    clear_inputs();
    reset = 1'b0;
    #1;
    chk("midrst_ack_pre_edge", 32'(ack), 0);
    cyc();
    chk("midrst_ack_release", 32'(ack), 32'hf);
    done = 4'hf;
    cyc();
    done = '0;
    chk("midrst_queues_empty", 32'(out_vld), 0);
    put_req(0, 4'b0001, 5'b11011, 5'b00100, 5'b00110, 5'b00000);
    cyc();
    clear_inputs();
    cyc();
    chk("midrst_first_vld", 32'(out_vld), 1);
    chk("midrst_first_tag", 32'(o_tag), 0);

    // Credit limit on port 2
    do_reset();
    put_req(1, 4'b0001, 5'b00110, 5'b01001, 5'b00011, 5'b00000);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (out_vld) cnt++;
    end
    chk("credit_dispatches", 32'(cnt), 4);
    chk("credit_ack_full", 32'(ack[1]), 0);
    clear_inputs();
    done[1] = 1'b1;
    cyc();
    chk("credit_done_edge_vld", 32'(out_vld), 0);
    done[1] = 1'b0;
    cyc();
    chk("credit_fifth_vld", 32'(out_vld), 1);
    chk("credit_fifth_tag", 32'(o_tag), 32'b0100);
    chk("credit_ack_back", 32'(ack[1]), 1);

    // Branch serialization on port 3
    do_reset();
    put_req(2, 4'b1100, 5'b10001, 5'b10010, 5'b00111, 5'b10101);
    cyc();
    put_req(2, 4'b0001, 5'b10011, 5'b10100, 5'b01000, 5'b00000);
    cyc();
    chk("br_grant_vld", 32'(out_vld), 1);
    chk("br_grant_bus", out_bus(),
        32'({4'b1100, 4'b1000, 5'b10001, 5'b10010, 5'b00111, 5'b10101}));
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("br_hold%0d", k), 32'(out_vld), 0);
    end
    done[2] = 1'b1;
    cyc();
    chk("br_done_edge_vld", 32'(out_vld), 0);
    done[2] = 1'b0;
    cyc();
    chk("br_follow_vld", 32'(out_vld), 1);
    chk("br_follow_bus", out_bus(),
        32'({4'b0001, 4'b1001, 5'b10011, 5'b10100, 5'b01000, 5'b00000}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_dispatch.md
# adder_dispatch

Issue side of the priority-to-adder command interface in calc3. Buffers adder-class commands from four requester ports in per-port queues, arbitrates round-robin, assigns tags, tracks per-port in-flight credits, and drives the `prio_adder_*` bus consumed by the adder input stage. Issues at most one command per cycle.

## Interface
- `QDEPTH`, 2: entries per port queue (power of 2, ≥2)
- `MAX_INFLIGHT`, 4: per-port in-flight limit; must not exceed 4 (2-bit sequence field)
- `c_clk`  in  1  sole clock; all state updates on negedge `c_clk`
- `reset`  in  1  synchronous, active-high
- `reqN_vld`  in  1  port N request valid (N = 1..4)
- `reqN_cmd`  in  [0:3]  command
- `reqN_data1`, `reqN_data2`  in  [0:4]  operand refs: bit 0 = read valid, [1:4] = register address
- `reqN_result`  in  [0:5]  result register
- `reqN_follow_branch`  in  [0:4]  branch follow field
- `reqN_ack`  out  1  port N can accept this cycle
- `doneN`  in  1  one port-N command retired (one-cycle pulse)
- `prio_adder_out_vld`  out  1  dispatch valid
- `prio_adder_cmd`, `prio_adder_tag`  out  [0:3]
- `prio_adder_data1`, `prio_adder_data2`, `prio_adder_follow_branch`, `prio_adder_result`  out  [0:4]

`reqN_result` is [0:4]; the [0:5] above is an error and is superseded.

## Operation
- Legal commands: 0001 add, 0010 sub, 1100 and 1101 branch. Any other code is acked and discarded without being enqueued.
- Handshake: `reqN_ack` = !queue_full(N) && !reset, decoded from registered state. Push when `reqN_vld && reqN_ack`. Holding `vld` high with ack low is a stall; the source holds fields stable.
- Eligible port: queue non-empty, inflight(N) < `MAX_INFLIGHT`, and branch_pending(N) clear.
- Arbitration: round-robin among eligible ports, starting at the port after the last granted one. After reset the pointer favours port 1.
- Grant actions:
  - pop the queue head
  - register all fields onto `prio_adder_*`
  - `prio_adder_tag` = {N-1 [0:1], seq(N) [0:1]}
  - seq(N) increments mod 4
  - inflight(N) increments
- Branch grant (1100/1101) sets branch_pending(N). It clears on the edge where inflight(N) reaches 0.
- inflight update on the same edge:
  - `doneN` only: −1
  - grant only: +1
  - both: unchanged
  - `doneN` when inflight = 0: ignored
- Push and pop on the same port in the same cycle are both performed, and occupancy is unchanged. This is legal when the queue is full, because ack is based on pre-edge state.
- No eligible port: `prio_adder_out_vld` = 0. Other `prio_adder_*` fields hold their previous values.

## Timing
- Latency: push at edge k → earliest `prio_adder_out_vld` at edge k+1, held for one cycle.
- Back-to-back dispatch is allowed every cycle.
- Reset, including mid-operation:
  - all `prio_adder_*` = 0, all `reqN_ack` = 0
  - queues emptied; seq, inflight, branch_pending = 0
  - round-robin pointer reset
  - in-flight commands are forgotten; later `doneN` pulses are ignored while inflight = 0
- First ack rises on the first edge with `reset` low.

## Configuration
- `CALC3_DISPATCH_ILLEGAL_CNT_EN` defined: adds output `illegal_cnt` [0:7].
  - increments on each acked illegal command, saturating at 255
  - simultaneous illegal pushes on several ports add their count in one edge
  - reset to 0
- Undefined: port absent, no counter logic; illegal commands are dropped silently.

## Structure
- Package `calc3_pkg` holds:
  - command encodings (CMD_ADD, CMD_SUB, CMD_BZ, CMD_BEQ)
  - legal/branch decode functions
  - NUM_PORTS = 4
  - tag field widths
  - the request-entry struct (cmd, data1, data2, result, follow_branch)
- Sub-module `adder_dispatch_fifo`: parameterized `QDEPTH` queue with push/pop/full/empty, instantiated once per port.

## Test plan
- Reset then single add: port 1 pushes cmd 0001, data1 10011, data2 10100 → next cycle `prio_adder_out_vld` = 1, cmd 0001, tag 0000, data fields passed through.
- Fairness: all four ports hold `vld` with legal commands → grants 1,2,3,4,1,… and tags 0000, 0100, 1000, 1100, 0001.
- Credit limit: port 2 issues 4 commands with no `done2` → 5th held, queue fills, `req2_ack` = 0; one `done2` pulse → 5th dispatches next cycle.
- Branch serialization: port 3 issues 1100 then 0001 → 0001 withheld until `done3` returns inflight to 0, then dispatched.
- Illegal command: port 4 sends 0101 → acked, nothing dispatched; `illegal_cnt` = 1 with macro defined.
- Mid-run reset: queues full and 3 in flight, `reset` pulsed → all outputs 0, acks 0; after release the first dispatch has seq 00, and stale `doneN` pulses are ignored.
